// File: rtl/pe_pkg.sv
// pe_pkg: shared swap-FSM states, default geometry and ring-pointer helper
package pe_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, ROTATE, ACK} swap_state_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 64;

    function automatic int ring_inc(input int p, input int n);
        return (p + 1) % n;
    endfunction

endpackage

// File: rtl/act_bank.sv
// act_bank: one activation bank with a write port, two read ports, bulk clear and zero/positive flags
module act_bank
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_a_addr,
    output logic [DATA_WIDTH-1:0] rd_a_data,
    input  logic [AW-1:0]         rd_b_addr,
    output logic [DATA_WIDTH-1:0] rd_b_data,
    output logic [DEPTH-1:0]      zeros,
    output logic [DEPTH-1:0]      g_zeros
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // storage: bulk clear wins over a write, out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en && int'(wr_addr) < DEPTH) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_a_data = (int'(rd_a_addr) < DEPTH) ? mem_q[rd_a_addr] : '0;
    assign rd_b_data = (int'(rd_b_addr) < DEPTH) ? mem_q[rd_b_addr] : '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flag
        assign zeros[g]   = mem_q[g] == '0;
        assign g_zeros[g] = !mem_q[g][DATA_WIDTH-1] && |mem_q[g];
    end

endmodule

// File: rtl/act_bank_ring.sv
// act_bank_ring: ring of activation banks with handshaked role rotation (optional ACT_BANK_RING_RELU_EN adds out_rd_data_relu)
module act_bank_ring
    import pe_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = $clog2(DEPTH),
    parameter int BW         = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  busy,
    output logic [BW-1:0]         in_sel,
    input  logic                  in_clear,
    input  logic                  in_rd_en,
    input  logic [AW-1:0]         in_rd_addr,
    output logic [DATA_WIDTH-1:0] in_rd_data,
    input  logic                  in_wr_en,
    input  logic [AW-1:0]         in_wr_addr,
    input  logic [DATA_WIDTH-1:0] in_wr_data,
    output logic [DEPTH-1:0]      in_zeros,
    output logic [DEPTH-1:0]      in_g_zeros,
    input  logic                  out_clear,
    input  logic                  out_rd_en,
    input  logic [AW-1:0]         out_rd_addr,
    output logic [DATA_WIDTH-1:0] out_rd_data,
    input  logic                  out_wr_en,
    input  logic [AW-1:0]         out_wr_addr,
    input  logic [DATA_WIDTH-1:0] out_wr_data,
    output logic [DEPTH-1:0]      out_g_zeros
`ifdef ACT_BANK_RING_RELU_EN
    ,output logic [DATA_WIDTH-1:0] out_rd_data_relu
`endif
);

    swap_state_e           state_q, state_d;
    logic [BW-1:0]         ptr_q, ptr_d, out_ptr, clr_ptr;
    logic [DATA_WIDTH-1:0] in_rd_q, in_rd_d, out_rd_q, out_rd_d;
    logic [DATA_WIDTH-1:0] rd_a [NUM_BANKS];
    logic [DATA_WIDTH-1:0] rd_b [NUM_BANKS];
    logic [DEPTH-1:0]      zeros_w [NUM_BANKS];
    logic [DEPTH-1:0]      g_zeros_w [NUM_BANKS];

    assign out_ptr  = BW'(ring_inc(int'(ptr_q), NUM_BANKS));
    assign clr_ptr  = BW'(ring_inc(int'(out_ptr), NUM_BANKS));
    assign busy     = state_q != IDLE;
    assign swap_ack = state_q == ACK;
    assign in_sel   = ptr_q;

    // swap sequencing plus next-state of the pointer and read registers
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = swap_req ? DRAIN : IDLE;
            DRAIN:   state_d = ROTATE;
            ROTATE:  state_d = ACK;
            default: state_d = IDLE;
        endcase
        ptr_d    = (state_q == ROTATE) ? out_ptr : ptr_q;
        in_rd_d  = (!busy && in_rd_en) ? rd_a[ptr_q] : in_rd_q;
        out_rd_d = (!busy && out_rd_en) ? rd_b[out_ptr] : out_rd_q;
    end

    // state, ring pointer and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            in_rd_q  <= '0;
            out_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            in_rd_q  <= in_rd_d;
            out_rd_q <= out_rd_d;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic is_in, is_out, clr;
        assign is_in  = ptr_q == BW'(g);
        assign is_out = out_ptr == BW'(g);
        assign clr    = (state_q == ROTATE && clr_ptr == BW'(g))
                      || (!busy && ((in_clear && is_in) || (out_clear && is_out)));
        act_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank (
            .clk       (clk),
            .rst       (rst),
            .clear     (clr),
            .wr_en     (!busy && ((in_wr_en && is_in) || (out_wr_en && is_out))),
            .wr_addr   (is_in ? in_wr_addr : out_wr_addr),
            .wr_data   (is_in ? in_wr_data : out_wr_data),
            .rd_a_addr (in_rd_addr),
            .rd_a_data (rd_a[g]),
            .rd_b_addr (out_rd_addr),
            .rd_b_data (rd_b[g]),
            .zeros     (zeros_w[g]),
            .g_zeros   (g_zeros_w[g])
        );
    end

    assign in_rd_data  = in_rd_q;
    assign out_rd_data = out_rd_q;
    assign in_zeros    = zeros_w[ptr_q];
    assign in_g_zeros  = g_zeros_w[ptr_q];
    assign out_g_zeros = g_zeros_w[out_ptr];

`ifdef ACT_BANK_RING_RELU_EN
    assign out_rd_data_relu = out_rd_q[DATA_WIDTH-1] ? '0 : out_rd_q;
`endif

endmodule

// File: tb/tb_act_bank_ring.sv
// tb_act_bank_ring: directed plus random stimulus against a bank-array reference model
module tb_act_bank_ring;

    localparam int NB = 3;
    localparam int DW = 16;
    localparam int DP = 12;
    localparam int AW = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          swap_req, swap_ack, busy;
    logic [BW-1:0] in_sel;
    logic          in_clear, in_rd_en, in_wr_en;
    logic [AW-1:0] in_rd_addr, in_wr_addr;
    logic [DW-1:0] in_rd_data, in_wr_data;
    logic [DP-1:0] in_zeros, in_g_zeros, out_g_zeros;
    logic          out_clear, out_rd_en, out_wr_en;
    logic [AW-1:0] out_rd_addr, out_wr_addr;
    logic [DW-1:0] out_rd_data, out_wr_data;
`ifdef ACT_BANK_RING_RELU_EN
    logic [DW-1:0] out_rd_data_relu;
`endif

    always #5 clk = ~clk;

    act_bank_ring #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .swap_req(swap_req), .swap_ack(swap_ack), .busy(busy), .in_sel(in_sel),
        .in_clear(in_clear), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
        .in_zeros(in_zeros), .in_g_zeros(in_g_zeros),
        .out_clear(out_clear), .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .out_g_zeros(out_g_zeros)
`ifdef ACT_BANK_RING_RELU_EN
        , .out_rd_data_relu(out_rd_data_relu)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    logic signed [DW-1:0] m_mem [NB][DP];
    int                   m_ptr, m_phase;
    logic [DW-1:0]        m_in_rd, m_out_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_zero(input int b);
        for (int e = 0; e < DP; e++) m_mem[b][e] = '0;
    endtask

    task automatic m_reset();
        for (int b = 0; b < NB; b++) m_zero(b);
        m_ptr = 0; m_phase = 0; m_in_rd = '0; m_out_rd = '0;
    endtask

    task automatic check_all();
        logic [DP-1:0] z, gz, ogz;
        int ob;
        ob = (m_ptr + 1) % NB;
        for (int e = 0; e < DP; e++) begin
            z[e]   = m_mem[m_ptr][e] == 0;
            gz[e]  = m_mem[m_ptr][e] > 0;
            ogz[e] = m_mem[ob][e] > 0;
        end
        chk("in_sel", 64'(in_sel), 64'(m_ptr));
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("swap_ack", 64'(swap_ack), 64'(m_phase == 3));
        chk("in_rd_data", 64'(in_rd_data), 64'(m_in_rd));
        chk("out_rd_data", 64'(out_rd_data), 64'(m_out_rd));
        chk("in_zeros", 64'(in_zeros), 64'(z));
        chk("in_g_zeros", 64'(in_g_zeros), 64'(gz));
        chk("out_g_zeros", 64'(out_g_zeros), 64'(ogz));
`ifdef ACT_BANK_RING_RELU_EN
        chk("relu", 64'(out_rd_data_relu), m_out_rd[DW-1] ? 64'd0 : 64'(m_out_rd));
`endif
    endtask

    // apply the rules for the coming edge to the model, then compare after it
    task automatic tick();
        int ob;
        ob = (m_ptr + 1) % NB;
        if (rst) begin
            m_reset();
        end else begin
            if (m_phase == 0) begin
                if (in_rd_en) m_in_rd = m_mem[m_ptr][int'(in_rd_addr)];
                if (out_rd_en) m_out_rd = m_mem[ob][int'(out_rd_addr)];
                if (in_clear) m_zero(m_ptr);
                else if (in_wr_en && int'(in_wr_addr) < DP) m_mem[m_ptr][int'(in_wr_addr)] = in_wr_data;
                if (out_clear) m_zero(ob);
                else if (out_wr_en && int'(out_wr_addr) < DP) m_mem[ob][int'(out_wr_addr)] = out_wr_data;
            end
            if (m_phase == 2) begin
                m_ptr = (m_ptr + 1) % NB;
                m_zero((m_ptr + 1) % NB);
            end
            m_phase = (m_phase == 3) ? 0 : (m_phase != 0) ? m_phase + 1 : (swap_req ? 1 : 0);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_ports();
        in_clear = 0; in_rd_en = 0; in_wr_en = 0; in_rd_addr = '0; in_wr_addr = '0; in_wr_data = '0;
        out_clear = 0; out_rd_en = 0; out_wr_en = 0; out_rd_addr = '0; out_wr_addr = '0; out_wr_data = '0;
    endtask

    task automatic rand_ports();
        in_clear    = $urandom_range(0, 15) == 0;
        out_clear   = $urandom_range(0, 15) == 0;
        in_rd_en    = 1'($urandom);
        out_rd_en   = 1'($urandom);
        in_wr_en    = 1'($urandom);
        out_wr_en   = 1'($urandom);
        in_rd_addr  = AW'($urandom_range(0, DP - 1));
        out_rd_addr = AW'($urandom_range(0, DP - 1));
        in_wr_addr  = AW'($urandom_range(0, 15));
        out_wr_addr = AW'($urandom_range(0, 15));
        in_wr_data  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
        out_wr_data = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
    endtask

    task automatic do_swap(input bit rnd);
        int k;
        k = 0;
        swap_req = 1;
        do begin
            if (rnd) rand_ports();
            tick();
            k++;
        end while (!swap_ack && k < 8);
        chk("ack_latency", 64'(k), 64'd3);
        swap_req = 0;
        idle_ports();
    endtask

    task automatic out_write(input int a, input logic [DW-1:0] d);
        out_wr_en = 1; out_wr_addr = AW'(a); out_wr_data = d;
        tick();
        idle_ports();
    endtask

    initial begin
        rst = 1; swap_req = 0;
        idle_ports();
        m_reset();
        tick();
        tick();
        rst = 0;
        chk("rst_in_zeros", 64'(in_zeros), 64'(12'hfff));
        chk("rst_in_sel", 64'(in_sel), 64'd0);

        in_rd_en = 1; out_rd_en = 1; in_rd_addr = 5; out_rd_addr = 5;
        tick();
        chk("rd5_in", 64'(in_rd_data), 64'd0);
        chk("rd5_out", 64'(out_rd_data), 64'd0);
        idle_ports();

        out_write(3, -16'sd7);
        out_write(4, 16'sd9);
        do_swap(0);
        chk("swap1_in_sel", 64'(in_sel), 64'd1);
        chk("swap1_zero3", 64'(in_zeros[3]), 64'd0);
        chk("swap1_gz4", 64'(in_g_zeros[4]), 64'd1);
        chk("swap1_gz3", 64'(in_g_zeros[3]), 64'd0);

        for (int i = 0; i < 3; i++) begin
            out_write(0, DW'(100 + i));
            do_swap(0);
            chk("ring_sel", 64'(in_sel), 64'((2 + i) % NB));
            for (int a = 0; a < 5; a++) begin
                in_rd_en = 1; in_rd_addr = AW'(a);
                tick();
            end
            idle_ports();
        end

        in_rd_en = 1; out_rd_en = 1; in_rd_addr = 0; out_rd_addr = 0;
        tick();
        do_swap(1);
        tick();

        out_write(2, 16'd33);
        out_wr_en = 1; out_wr_addr = 2; out_wr_data = 16'd11; out_rd_en = 1; out_rd_addr = 2;
        tick();
        chk("rbw_old", 64'(out_rd_data), 64'd33);
        idle_ports();
        out_rd_en = 1; out_rd_addr = 2;
        tick();
        chk("rbw_new", 64'(out_rd_data), 64'd11);
        idle_ports();
        out_clear = 1; out_wr_en = 1; out_wr_addr = 2; out_wr_data = 16'd5;
        tick();
        idle_ports();
        out_rd_en = 1; out_rd_addr = 2;
        tick();
        chk("clr_wins", 64'(out_rd_data), 64'd0);
        idle_ports();

`ifdef ACT_BANK_RING_RELU_EN
        out_write(1, -16'sd4);
        out_rd_en = 1; out_rd_addr = 1;
        tick();
        chk("relu_neg", 64'(out_rd_data_relu), 64'd0);
        idle_ports();
`endif

        for (int c = 0; c < 400; c++) begin
            rand_ports();
            swap_req = swap_req ? !swap_ack : ($urandom_range(0, 15) == 0);
            tick();
        end
        swap_req = 0;
        idle_ports();
        tick();
        tick();
        tick();
        tick();

        out_write(6, 16'd77);
        swap_req = 1;
        tick();
        tick();
        rst = 1;
        tick();
        chk("rst_mid_sel", 64'(in_sel), 64'd0);
        chk("rst_mid_zeros", 64'(in_zeros), 64'(12'hfff));
        rst = 0; swap_req = 0;
        tick();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
